// File: rtl/ram_loader_pkg.sv
// Shared loader definitions: FSM state encoding and error codes,
// also used by the status/LED display logic.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        VERIFY,
        DRAIN,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CKSUM    = 2'b01;
    localparam logic [1:0] ERR_READBACK = 2'b10;

endpackage

// File: rtl/ram_loader_sum.sv
// Modulo-2^DW byte accumulator with synchronous clear and add enable.
module loader_sum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic          add,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] sum
);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Programming-mode sequencer: streams 16 bytes plus checksum into RAM,
// then reads the RAM back and confirms the checksum.
import ram_loader_pkg::*;

module ram_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          rd_vld;
    logic [DW-1:0] ck_byte;
    logic [DW-1:0] load_sum;
    logic [DW-1:0] rb_sum;
    logic [1:0]    err_q;
    logic          xfer;
    logic          restart;
    logic          idle_like;

    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign restart   = start && idle_like;
    assign xfer      = in_valid && in_ready;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (xfer && wr_cnt == LAST) state_nx = CHECK;
            end
            CHECK: begin
                if (xfer) state_nx = (in_data == load_sum) ? VERIFY : ERROR;
            end
            VERIFY: begin
                if (rd_cnt == LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                // the cycle after the final word lands, the sum is complete
                if (!rd_vld) state_nx = (rb_sum == ck_byte) ? DONE : ERROR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        rd_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            LOAD, CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            VERIFY: begin
                rd_en = 1'b1;
                busy  = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign cpu_hold = busy;
    assign rd_addr  = rd_cnt;
    assign err_code = err_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_vld  <= 1'b0;
            ck_byte <= '0;
            err_q   <= ERR_NONE;
        end else begin
            wr_en  <= (state == LOAD) && xfer;
            rd_vld <= (state == VERIFY);
            if (restart) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                ck_byte <= '0;
                err_q   <= ERR_NONE;
            end
            if (state == LOAD && xfer) begin
                wr_addr <= wr_cnt;
                wr_data <= in_data;
                wr_cnt  <= wr_cnt + 1'b1;
            end
            if (state == VERIFY) rd_cnt <= rd_cnt + 1'b1;
            if (state == CHECK && xfer) begin
                ck_byte <= in_data;
                if (in_data != load_sum) err_q <= ERR_CKSUM;
            end
            if (state == DRAIN && !rd_vld && rb_sum != ck_byte) begin
                err_q <= ERR_READBACK;
            end
        end
    end

    loader_sum #(.DW(DW)) u_load_sum (
        .clk (clk),
        .res (res),
        .clr (restart),
        .add ((state == LOAD) && xfer),
        .din (in_data),
        .sum (load_sum)
    );

    loader_sum #(.DW(DW)) u_rb_sum (
        .clk (clk),
        .res (res),
        .clr (restart),
        .add (rd_vld),
        .din (rd_data),
        .sum (rb_sum)
    );

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a RAM model and
// a write-order scoreboard.
module tb_ram_loader;
    import ram_loader_pkg::*;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    logic [7:0] mem [16];
    bit         fault_en = 1'b0;
    int         cyc = 0;

    logic [7:0] stream [16] = '{8'h4B, 8'h1F, 8'h2E, 8'hF0,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h2A, 8'h2F};

    logic [11:0] sb [$];
    logic [11:0] exp_w;
    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;

    int obs_end, obs_hf, obs_hl, obs_rd;

    ram_loader dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with registered read port and optional stuck byte at 5
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= (fault_en && rd_addr == 4'd5) ? 8'hFF : mem[rd_addr];
    end

    always @(negedge clk) begin
        if (res && wr_en) begin
            n_wr++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, none expected",
                         wr_addr, wr_data);
            end else begin
                exp_w = sb.pop_front();
                if ({wr_addr, wr_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL wr_order: got addr=%0d data=%h, need addr=%0d data=%h",
                             wr_addr, wr_data, exp_w[11:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic run(input logic [7:0] ck, input int maxgap, input bit mid_start);
        int s0;
        obs_end = -1;
        obs_hf = -1;
        obs_hl = -1;
        obs_rd = 0;
        @(posedge clk);
        #1;
        s0 = cyc;
        start = 1'b1;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    int g;
                    bit got;
                    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                    in_valid = 1'b0;
                    repeat (g) begin
                        @(posedge clk);
                        #1;
                    end
                    in_valid = 1'b1;
                    in_data = (i < 16) ? stream[i] : ck;
                    got = 1'b0;
                    for (int w = 0; w < 100 && !got; w++) begin
                        @(negedge clk);
                        got = in_ready;
                        @(posedge clk);
                        #1;
                    end
                    if (got && i < 16) sb.push_back({4'(i), stream[i]});
                end
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
                if (mid_start) begin
                    while (cyc - s0 < 25) begin
                        @(posedge clk);
                        #1;
                    end
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            begin
                for (int k = 0; k <= 400; k++) begin
                    int kk;
                    @(negedge clk);
                    kk = cyc - s0;
                    if (cpu_hold) begin
                        if (obs_hf < 0) obs_hf = kk;
                        obs_hl = kk;
                    end
                    if (rd_en) obs_rd++;
                    if (kk > 0 && (done || err_code != ERR_NONE)) begin
                        obs_end = kk;
                        break;
                    end
                end
            end
        join
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, wr_en, rd_en, cpu_hold, busy, done, err_code,
             wr_addr, rd_addr, wr_data} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b err=%b wa=%0d ra=%0d wd=%h, need all 0",
                     in_ready, wr_en, rd_en, cpu_hold, busy, done, err_code,
                     wr_addr, rd_addr, wr_data);
        end
        res = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_nominal();
        int w0;
        w0 = n_wr;
        run(8'hE1, 0, 1'b0);
        n_cmp++;
        if (obs_end !== 36) begin
            n_bad++;
            $display("FAIL nom_done_cycle: got %0d, need 36", obs_end);
        end
        n_cmp++;
        if (done !== 1'b1 || err_code !== ERR_NONE) begin
            n_bad++;
            $display("FAIL nom_status: got done=%b err=%b, need 1/00", done, err_code);
        end
        n_cmp++;
        if (obs_hf !== 1 || obs_hl !== 35) begin
            n_bad++;
            $display("FAIL nom_hold: got %0d..%0d, need 1..35", obs_hf, obs_hl);
        end
        n_cmp++;
        if (obs_rd !== 16 || n_wr - w0 !== 16) begin
            n_bad++;
            $display("FAIL nom_counts: got rd=%0d wr=%0d, need 16/16", obs_rd, n_wr - w0);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem[i] !== stream[i]) begin
                n_bad++;
                $display("FAIL nom_ram[%0d]: got %h, need %h", i, mem[i], stream[i]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        run(8'hE0, 0, 1'b0);
        n_cmp++;
        if (err_code !== ERR_CKSUM || done !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_ck_status: got done=%b err=%b, need 0/01", done, err_code);
        end
        n_cmp++;
        if (obs_rd !== 0 || obs_end !== 18) begin
            n_bad++;
            $display("FAIL bad_ck_timing: got rd=%0d end=%0d, need 0/18", obs_rd, obs_end);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_ck_idle: got ready=%b busy=%b, need 0/0", in_ready, busy);
        end
    endtask

    task automatic test_readback_fault();
        fault_en = 1'b1;
        run(8'hE1, 0, 1'b0);
        fault_en = 1'b0;
        n_cmp++;
        if (err_code !== ERR_READBACK || done !== 1'b0 || obs_end !== 36) begin
            n_bad++;
            $display("FAIL rb_fault: got done=%b err=%b end=%0d, need 0/10/36",
                     done, err_code, obs_end);
        end
    endtask

    task automatic test_stall();
        int w0;
        w0 = n_wr;
        run(8'hE1, 3, 1'b0);
        n_cmp++;
        if (done !== 1'b1 || err_code !== ERR_NONE) begin
            n_bad++;
            $display("FAIL stall_status: got done=%b err=%b, need 1/00", done, err_code);
        end
        n_cmp++;
        if (n_wr - w0 !== 16 || sb.size() !== 0) begin
            n_bad++;
            $display("FAIL stall_writes: got %0d left=%0d, need 16/0", n_wr - w0, sb.size());
        end
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk);
        #1;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = stream[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_data = stream[i];
            sb.push_back({4'(i), stream[i]});
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd6) begin
            n_bad++;
            $display("FAIL mid_pre: got wr_en=%b addr=%0d, need 1/6", wr_en, wr_addr);
        end
        res = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, wr_en, rd_en, cpu_hold, busy, done, err_code,
             wr_addr, rd_addr, wr_data} !== 24'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b/%b/%b/%b/%b/%b err=%b wa=%0d wd=%h, need all 0",
                     in_ready, wr_en, rd_en, cpu_hold, busy, done, err_code,
                     wr_addr, wr_data);
        end
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        n_cmp++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_held: got wr_en=%b busy=%b, need 0/0", wr_en, busy);
        end
        res = 1'b1;
        run(8'hE1, 0, 1'b0);
        n_cmp++;
        if (done !== 1'b1 || err_code !== ERR_NONE || obs_end !== 36) begin
            n_bad++;
            $display("FAIL mid_rerun: got done=%b err=%b end=%0d, need 1/00/36",
                     done, err_code, obs_end);
        end
    endtask

    task automatic test_start_busy();
        run(8'hE1, 0, 1'b1);
        n_cmp++;
        if (done !== 1'b1 || err_code !== ERR_NONE || obs_end !== 36 || obs_rd !== 16) begin
            n_bad++;
            $display("FAIL start_busy: got done=%b err=%b end=%0d rd=%0d, need 1/00/36/16",
                     done, err_code, obs_end, obs_rd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_readback_fault();
        test_stall();
        test_reset_mid_load();
        test_start_busy();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, need 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
